// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: debounced-key FSM that loads operands and an opcode into an external ALU,
// runs one execute cycle and holds the captured result.
package alu_op_sequencer_pkg;
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;
endpackage

module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] operand_in,
    input  logic [1:0] op_in,
    input  logic       key_next_n,
    input  logic       key_clear_n,
    output logic [4:0] alu_num1,
    output logic [4:0] alu_num2,
    output logic [1:0] alu_op,
    input  logic [9:0] alu_result,
    output logic [9:0] result,
    output logic [2:0] state,
    output logic       done,
    output logic [7:0] op_count
);
    state_t st;
    logic [SYNC_STAGES-1:0] sync_next, sync_clear;
    logic prev_next, prev_clear, next_ev, clear_ev;

    // A press is the synchronized level falling; holding the key yields a single pulse.
    assign next_ev  = prev_next & ~sync_next[SYNC_STAGES-1];
    assign clear_ev = prev_clear & ~sync_clear[SYNC_STAGES-1];
    assign state    = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_next  <= '1;
            sync_clear <= '1;
            prev_next  <= 1'b1;
            prev_clear <= 1'b1;
        end else begin
            sync_next  <= {sync_next[SYNC_STAGES-2:0], key_next_n};
            sync_clear <= {sync_clear[SYNC_STAGES-2:0], key_clear_n};
            prev_next  <= sync_next[SYNC_STAGES-1];
            prev_clear <= sync_clear[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_A;
            alu_num1 <= '0;
            alu_num2 <= '0;
            alu_op   <= '0;
            result   <= '0;
            op_count <= '0;
            done     <= 1'b0;
        end else if (clear_ev) begin
            st       <= S_A;
            alu_num1 <= '0;
            alu_num2 <= '0;
            alu_op   <= '0;
            done     <= 1'b0;
        end else begin
            case (st)
                S_A: if (next_ev) begin
                    alu_num1 <= operand_in;
                    st       <= S_B;
                end
                S_B: if (next_ev) begin
                    alu_num2 <= operand_in;
                    st       <= S_OP;
                end
                S_OP: if (next_ev) begin
                    alu_op <= op_in;
                    st     <= S_EXEC;
                end
                S_EXEC: begin
                    result   <= alu_result;
                    op_count <= op_count + {7'd0, op_count != 8'hFF};
                    done     <= 1'b1;
                    st       <= S_SHOW;
                end
                S_SHOW: if (next_ev) begin
                    done <= 1'b0;
                    st   <= S_A;
                end
                default: begin
                    done <= 1'b0;
                    st   <= S_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized scenario bench with a transaction-level reference model.
module tb_alu_op_sequencer;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] operand_in = '0;
    logic [1:0] op_in = '0;
    logic       key_next_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [4:0] alu_num1, alu_num2;
    logic [1:0] alu_op;
    logic [9:0] alu_result, result;
    logic [2:0] state;
    logic       done;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_st;
    logic [4:0] exp_n1, exp_n2;
    logic [1:0] exp_op;
    logic [9:0] exp_res;
    int         exp_cnt;

    always #5 clk = ~clk;

    function automatic logic [9:0] alu_ref(input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
        case (o)
            2'b00:   return {5'd0, a} + {5'd0, b};
            2'b01:   return {5'd0, a} - {5'd0, b};
            2'b10:   return {5'd0, a} * {5'd0, b};
            default: return {5'd0, a ^ b};
        endcase
    endfunction

    assign alu_result = alu_ref(alu_num1, alu_num2, alu_op);

    alu_op_sequencer #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .operand_in(operand_in), .op_in(op_in),
        .key_next_n(key_next_n), .key_clear_n(key_clear_n),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
        .alu_result(alu_result), .result(result), .state(state),
        .done(done), .op_count(op_count)
    );

    task automatic model_reset();
        exp_st = 3'd0; exp_n1 = '0; exp_n2 = '0; exp_op = '0; exp_res = '0; exp_cnt = 0;
    endtask

    task automatic model_clear();
        exp_st = 3'd0; exp_n1 = '0; exp_n2 = '0; exp_op = '0;
    endtask

    // One completed next press: operand/op capture, or a whole execution when leaving S_OP.
    task automatic model_next(input logic [4:0] opd, input logic [1:0] o);
        case (exp_st)
            3'd0: begin exp_n1 = opd; exp_st = 3'd1; end
            3'd1: begin exp_n2 = opd; exp_st = 3'd2; end
            3'd2: begin
                exp_op  = o;
                exp_res = alu_ref(exp_n1, exp_n2, o);
                exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                exp_st  = 3'd4;
            end
            default: exp_st = 3'd0;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_next_n = 1'b1; key_clear_n = 1'b1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input bit nx, input bit cl, input logic [4:0] opd, input logic [1:0] o);
        @(negedge clk);
        operand_in = opd; op_in = o;
        key_next_n = ~nx; key_clear_n = ~cl;
        repeat (2) @(negedge clk);
        key_next_n = 1'b1; key_clear_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        if (cl) model_clear();
        else if (nx) model_next(opd, o);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, alu_num1, alu_num2, alu_op, result, done, op_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_async: got st=%0d n1=%0d n2=%0d op=%0d res=%0d done=%0d cnt=%0d, want all 0",
                     state, alu_num1, alu_num2, alu_op, result, done, op_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        checks++;
        if (state !== 3'd0 || op_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_no_spurious: got st=%0d cnt=%0d, want 0 0", state, op_count);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        operand_in = 5'd17; key_next_n = 1'b0;
        repeat (S) @(negedge clk);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL latency_early: got st=%0d after %0d edges, want 0", state, S);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || alu_num1 !== 5'd17) begin
            errors++;
            $display("FAIL latency_exact: got st=%0d n1=%0d after %0d edges, want 1 17", state, alu_num1, S + 1);
        end
        key_next_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        model_next(5'd17, 2'b00);
        press(1'b0, 1'b1, 5'd0, 2'b00);
    endtask

    task automatic test_full_sequence();
        int exec_cycles;
        press(1'b1, 1'b0, 5'd5, 2'b00);
        press(1'b1, 1'b0, 5'd9, 2'b00);
        @(negedge clk);
        op_in = 2'b00; key_next_n = 1'b0;
        exec_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) key_next_n = 1'b1;
            if (state == 3'd3) exec_cycles++;
        end
        model_next(5'd0, 2'b00);
        checks++;
        if (exec_cycles != 1) begin
            errors++;
            $display("FAIL exec_length: got %0d cycles in S_EXEC, want 1", exec_cycles);
        end
        checks++;
        if (alu_num1 !== 5'd5 || alu_num2 !== 5'd9 || result !== 10'd14 || done !== 1'b1
            || op_count !== 8'd1 || state !== 3'd4) begin
            errors++;
            $display("FAIL full_seq: got n1=%0d n2=%0d res=%0d done=%0d cnt=%0d st=%0d, want 5 9 14 1 1 4",
                     alu_num1, alu_num2, result, done, op_count, state);
        end
        press(1'b1, 1'b0, 5'd0, 2'b00);
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || result !== 10'd14 || alu_num1 !== 5'd5) begin
            errors++;
            $display("FAIL show_exit: got st=%0d done=%0d res=%0d n1=%0d, want 0 0 14 5",
                     state, done, result, alu_num1);
        end
    endtask

    task automatic test_hold();
        int changes;
        logic [2:0] last;
        @(negedge clk);
        operand_in = 5'd3; key_next_n = 1'b0;
        last = state;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state != last) changes++;
            last = state;
        end
        key_next_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        model_next(5'd3, 2'b00);
        checks++;
        if (changes != 1 || state !== exp_st || alu_num1 !== 5'd3) begin
            errors++;
            $display("FAIL hold_key: got %0d transitions st=%0d n1=%0d, want 1 %0d 3", changes, state, alu_num1, exp_st);
        end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b0, 5'd11, 2'b00);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL reach_op: got st=%0d, want 2", state);
        end
        press(1'b1, 1'b1, 5'd4, 2'b11);
        checks++;
        if (state !== 3'd0 || alu_num1 !== 5'd0 || alu_num2 !== 5'd0 || alu_op !== 2'd0
            || op_count !== 8'(exp_cnt) || result !== exp_res) begin
            errors++;
            $display("FAIL next_clear_same: got st=%0d n1=%0d n2=%0d op=%0d cnt=%0d res=%0d, want 0 0 0 0 %0d %0d",
                     state, alu_num1, alu_num2, alu_op, op_count, result, exp_cnt, exp_res);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit cl;
            cl = ($urandom_range(0, 7) == 0);
            press(~cl, cl, 5'($urandom), 2'($urandom));
            checks++;
            if ({state, alu_num1, alu_num2, alu_op, result, done, op_count}
                !== {exp_st, exp_n1, exp_n2, exp_op, exp_res, exp_st == 3'd4, 8'(exp_cnt)}) begin
                errors++;
                $display("FAIL random_%0d: got st=%0d n1=%0d n2=%0d op=%0d res=%0d done=%0d cnt=%0d, want %0d %0d %0d %0d %0d %0d %0d",
                         i, state, alu_num1, alu_num2, alu_op, result, done, op_count,
                         exp_st, exp_n1, exp_n2, exp_op, exp_res, exp_st == 3'd4, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_exec();
        bit seen;
        press(1'b0, 1'b1, 5'd0, 2'b00);
        press(1'b1, 1'b0, 5'd7, 2'b00);
        press(1'b1, 1'b0, 5'd8, 2'b00);
        @(negedge clk);
        op_in = 2'b10; key_next_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (state == 3'd3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_exec: timeout, state=%0d want 3", state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || result !== 10'd0 || op_count !== 8'd0 || alu_num1 !== 5'd0) begin
            errors++;
            $display("FAIL reset_in_exec: got st=%0d res=%0d cnt=%0d n1=%0d, want 0 0 0 0",
                     state, result, op_count, alu_num1);
        end
        key_next_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (state !== 3'd0 || op_count !== 8'd0 || result !== 10'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got st=%0d cnt=%0d res=%0d, want 0 0 0", state, op_count, result);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            press(1'b1, 1'b0, 5'($urandom), 2'b00);
            press(1'b1, 1'b0, 5'($urandom), 2'b00);
            press(1'b1, 1'b0, 5'd0, 2'($urandom));
            if (i == 254 || i == 259) begin
                checks++;
                if (op_count !== 8'(exp_cnt) || result !== exp_res) begin
                    errors++;
                    $display("FAIL saturation_%0d: got cnt=%0d res=%0d, want %0d %0d", i, op_count, result, exp_cnt, exp_res);
                end
            end
            press(1'b1, 1'b0, 5'd0, 2'b00);
        end
        checks++;
        if (op_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation_final: got cnt=%0d, want 255", op_count);
        end
    endtask

    task automatic test_bad_state();
        press(1'b1, 1'b0, 5'd2, 2'b00);
        @(negedge clk);
        force dut.st = alu_op_sequencer_pkg::state_t'(3'd6);
        #1;
        release dut.st;
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL illegal_state: got st=%0d one cycle after forcing 6, want 0", state);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_full_sequence();
        test_hold();
        test_simultaneous();
        test_random();
        test_reset_exec();
        test_saturation();
        test_bad_state();
        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
